// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
// OPMODE values, OPMODE field positions, FSM state encoding and the tag record.
package dsp_ctrl_pkg;

    localparam logic [7:0] OPM_FIRST = 8'h01;   // X=M, Z=0
    localparam logic [7:0] OPM_ACC   = 8'h09;   // X=M, Z=P

    localparam int OPM_X_LSB       = 0;
    localparam int OPM_X_MSB       = 1;
    localparam int OPM_Z_LSB       = 2;
    localparam int OPM_Z_MSB       = 3;
    localparam int OPM_PREADD_SEL  = 4;
    localparam int OPM_CARRYIN     = 5;
    localparam int OPM_PREADD_SUB  = 6;
    localparam int OPM_POSTADD_SUB = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic vld;
        logic fst;
        logic lst;
    } tag_t;

endpackage

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Shift register of {vld, fst, lst} tags that tracks each operand pair
// through the slice register stages; stage 0 loads on every clock.
module dsp_tag_pipe
    import dsp_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  tag_t             tag_i,
    output logic [DEPTH-1:0] vld_o,
    output logic             fst_last_o,
    output logic             lst_last_o
);

    tag_t stage_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_stage
        if (gi == 0) begin : gen_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stage_q[gi] <= '0;
                else     stage_q[gi] <= tag_i;
            end
        end else begin : gen_tail
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stage_q[gi] <= '0;
                else     stage_q[gi] <= stage_q[gi-1];
            end
        end
        assign vld_o[gi] = stage_q[gi].vld;
    end

    assign fst_last_o = stage_q[DEPTH-1].fst;
    assign lst_last_o = stage_q[DEPTH-1].lst;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (AREG=BREG=MREG=PREG=1) through an N-term MAC:
// handshakes operand pairs and drives the stage clock enables and OPMODE.
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_WIDTH = 8,
    parameter int PIPE_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 dsp_cea,
    output logic                 dsp_ceb,
    output logic                 dsp_cem,
    output logic                 dsp_cep,
    output logic [7:0]           dsp_opmode,
    output logic                 busy,
    output logic                 done
);

    localparam int DEPTH = PIPE_LAT - 1;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 first_q, first_d;
    logic                 accept;
    logic                 last_pair;
    tag_t                 tag_in;
    logic [DEPTH-1:0]     vld;
    logic                 fst_last;
    logic                 lst_last;

    assign in_ready  = (state_q == ST_RUN);
    assign accept    = in_valid & in_ready;
    assign last_pair = (remaining_q == LEN_WIDTH'(1));

    assign tag_in = '{vld: accept, fst: accept & first_q, lst: accept & last_pair};

    dsp_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .tag_i      (tag_in),
        .vld_o      (vld),
        .fst_last_o (fst_last),
        .lst_last_o (lst_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_d     = ST_RUN;
                    remaining_d = len;
                    first_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    first_d     = 1'b0;
                    if (last_pair) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the final product is being written into P.
                if (vld[DEPTH-1] && lst_last) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign dsp_cea = accept;
    assign dsp_ceb = accept;
    assign dsp_cem = vld[0];
    assign dsp_cep = vld[DEPTH-1];
    // Idle value is OPM_FIRST so reset and bubbles present the safe load mode.
    assign dsp_opmode = (vld[DEPTH-1] && !fst_last) ? OPM_ACC : OPM_FIRST;

endmodule
